// File: rtl/div_unit.sv
// div_unit: iterative restoring divider, one quotient bit per cycle, WIDTH-cycle latency.
// Signed DIV support is compiled in only when DIV_UNIT_SIGNED_EN is defined.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] quo, rem, den, a_mag, b_mag, q_next, r_next, q_fin, r_fin;
    logic [WIDTH:0] sh;
    logic dz, ge, accept, last;
    assign busy = state == CALC;
    assign accept = start && !cancel && state != CALC;
    assign last = cnt == CW'(WIDTH - 1);
    // quo shifts the dividend out from the top while quotient bits enter at the bottom
    assign sh = {rem, quo[WIDTH-1]};
    assign ge = sh >= {1'b0, den};
    assign q_next = {quo[WIDTH-2:0], ge};
    assign r_next = ge ? WIDTH'(sh - {1'b0, den}) : sh[WIDTH-1:0];
`ifdef DIV_UNIT_SIGNED_EN
    logic sa, sb, neg_q, neg_r;
    assign sa = is_signed & dividend[WIDTH-1];
    assign sb = is_signed & divisor[WIDTH-1];
    assign a_mag = sa ? -dividend : dividend;
    assign b_mag = sb ? -divisor : divisor;
    assign q_fin = neg_q ? -q_next : q_next;
    assign r_fin = neg_r ? -r_next : r_next;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= sa ^ sb;
            neg_r <= sa;
        end
    end
`else
    logic unused_sign;
    assign unused_sign = is_signed;
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_fin = q_next;
    assign r_fin = r_next;
`endif
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt <= '0;
            done <= 1'b0;
            quotient <= '0;
            remainder <= '0;
            div_by_zero <= 1'b0;
            quo <= '0;
            rem <= '0;
            den <= '0;
            dz <= 1'b0;
        end else if (cancel) begin
            state <= IDLE;
            done <= 1'b0;
        end else if (accept) begin
            state <= CALC;
            cnt <= '0;
            done <= 1'b0;
            quo <= a_mag;
            rem <= '0;
            den <= b_mag;
            dz <= divisor == '0;
        end else if (state == CALC) begin
            quo <= q_next;
            rem <= r_next;
            cnt <= cnt + 1'b1;
            if (last) begin
                state <= DONE;
                done <= 1'b1;
                // a zero divisor leaves the dividend as remainder; only the quotient needs forcing
                quotient <= dz ? '1 : q_fin;
                remainder <= r_fin;
                div_by_zero <= dz;
            end
        end else begin
            state <= IDLE;
            done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an arithmetic reference model.
module tb_div_unit;
    localparam int W = 32;
    logic clk = 1'b0, resetn = 1'b1, start = 1'b0, is_signed = 1'b0, cancel = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0;
    logic busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;
    int checks = 0, errors = 0, edge_n = 0, due = 0;
    logic pend = 1'b0, exp_done = 1'b0, hz = 1'b0, pz = 1'b0;
    logic [W-1:0] hq = '0, hr = '0, pq = '0, pr = '0;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .cancel(cancel), .busy(busy),
        .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic void model_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                      output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb;
        logic sg;
`ifdef DIV_UNIT_SIGNED_EN
        sg = s;
`else
        sg = s & 1'b0;
`endif
        sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
        z = b == '0;
        if (z) begin
            q = '1;
            r = a;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endfunction

    // reference: each accepted request resolves exactly W edges later unless cancelled or reset
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend = 1'b0;
            exp_done = 1'b0;
            hq = '0;
            hr = '0;
            hz = 1'b0;
        end else begin
            edge_n++;
            exp_done = 1'b0;
            if (cancel) pend = 1'b0;
            else if (start && !pend) begin
                pend = 1'b1;
                due = edge_n + W;
                model_div(dividend, divisor, is_signed, pq, pr, pz);
            end else if (pend && edge_n == due) begin
                pend = 1'b0;
                exp_done = 1'b1;
                hq = pq;
                hr = pr;
                hz = pz;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, pend);
        chk("done", done, exp_done);
        chk("quotient", quotient, hq);
        chk("remainder", remainder, hr);
        chk("div_by_zero", div_by_zero, hz);
    end

    task automatic wait_done(input int k, input string name);
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, " latency"}, W'(edge_n - k), W);
    endtask

    task automatic run(input logic now, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez, input string name);
        int k;
        if (!now) @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        is_signed = s;
        @(negedge clk);
        start = 1'b0;
        k = edge_n;
        wait_done(k, name);
        chk({name, " q"}, quotient, eq);
        chk({name, " r"}, remainder, er);
        chk({name, " z"}, div_by_zero, ez);
    endtask

    task automatic no_done(input string name);
        logic seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= done;
        end
        chk(name, seen, 1'b0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] q, r;
        logic z;
        int k;
        model_div(32'd100, 32'd7, 1'b0, q, r, z);
        chk("model 100/7 q", q, 32'd14);
        chk("model 100/7 r", r, 32'd2);
        model_div(32'd5, 32'd0, 1'b0, q, r, z);
        chk("model 5/0 q", q, 32'hFFFF_FFFF);
        chk("model 5/0 z", z, 1'b1);
        model_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, z);
`ifdef DIV_UNIT_SIGNED_EN
        chk("model -7/2 q", q, 32'hFFFF_FFFD);
        chk("model -7/2 r", r, 32'hFFFF_FFFF);
`else
        chk("model -7/2 q", q, 32'h7FFF_FFFC);
        chk("model -7/2 r", r, 32'd1);
`endif
        #1 resetn = 1'b0;
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset q", quotient, '0);
        chk("reset r", remainder, '0);
        chk("reset z", div_by_zero, 1'b0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        run(1'b0, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, "100/7");
`ifdef DIV_UNIT_SIGNED_EN
        run(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "-7/2");
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, "minneg/-1");
`else
        run(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, "-7/2");
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, "minneg/-1");
`endif
        run(1'b0, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, "5/0");
        run(1'b0, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, "100/7 again");
        @(negedge clk);
        start = 1'b1;
        dividend = 32'd1000;
        divisor = 32'd3;
        is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel busy", busy, 1'b0);
        no_done("cancel no done");
        chk("cancel held q", quotient, 32'd14);
        chk("cancel held r", remainder, 32'd2);
        @(negedge clk);
        start = 1'b1;
        dividend = 32'd1000;
        divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        k = edge_n;
        repeat (5) @(negedge clk);
        start = 1'b1;
        dividend = 32'd9;
        divisor = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(k, "restart ignored");
        chk("restart ignored q", quotient, 32'd333);
        chk("restart ignored r", remainder, 32'd1);
        run(1'b1, 32'd77, 32'd10, 1'b0, 32'd7, 32'd7, 1'b0, "back-to-back");
        @(negedge clk);
        start = 1'b1;
        dividend = 32'd50;
        divisor = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("midcalc reset busy", busy, 1'b0);
        chk("midcalc reset q", quotient, '0);
        chk("midcalc reset r", remainder, '0);
        @(negedge clk);
        resetn = 1'b1;
        no_done("reset no done");
        run(1'b0, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, "after reset");
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = $urandom_range(0, 9) == 0;
            cancel = $urandom_range(0, 199) == 0;
            is_signed = 1'($urandom_range(0, 1));
            dividend = pick();
            divisor = pick();
        end
        @(negedge clk);
        start = 1'b0;
        cancel = 1'b0;
        repeat (40) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
